// File: rtl/afifo_rd_arbiter_if.sv
// Read-port bundle between the async FIFO / consumers and the read arbiter.
// The slave side is the arbiter, the master side owns the FIFO and requesters.
interface afifo_rd_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int LEN_W      = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic [NUM_REQ-1:0]       gnt;
    logic                     rempty;
    logic [DATA_WIDTH-1:0]    rdata;
    logic                     rinc;
    logic                     out_valid;
    logic [DATA_WIDTH-1:0]    out_data;
    logic [ID_W-1:0]          out_id;
    logic                     out_last;
    logic                     done;
    logic                     timeout;
    logic                     busy;

    modport master (
        output req, req_len, rempty, rdata,
        input  gnt, rinc, out_valid, out_data,
        input  out_id, out_last, done, timeout, busy
    );

    modport slave (
        input  req, req_len, rempty, rdata,
        output gnt, rinc, out_valid, out_data,
        output out_id, out_last, done, timeout, busy
    );
endinterface

// File: rtl/afifo_rd_arbiter.sv
// Round-robin burst scheduler for the async FIFO read port.
// Pops only while non-empty; aborts bursts that starve too long.
module afifo_rd_arbiter #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_REQ         = 4,
    parameter int LEN_W           = 8,
    parameter int MAX_EMPTY_RETRY = 10
) (
    input  logic              rclk,
    input  logic              rrst_n,
    afifo_rd_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int EC_W = $clog2(MAX_EMPTY_RETRY + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] READ = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [ID_W-1:0]       rr_q, rr_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [LEN_W-1:0]      rem_q, rem_d;
    logic [EC_W-1:0]       ec_q, ec_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic                  busy_q, busy_d;
    logic                  ov_q, ov_d;
    logic [DATA_WIDTH-1:0] od_q, od_d;
    logic [ID_W-1:0]       oid_q, oid_d;
    logic                  last_q, last_d;
    logic                  done_q, done_d;
    logic                  to_q, to_d;

    logic                  found;
    logic [ID_W-1:0]       win;
    logic                  rinc;
    int                    idx;

    assign rinc = (state_q == READ) && !bus.rempty && (rem_q != '0);

    // First requester at or after rr_q, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_q) + k) % NUM_REQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        rem_d   = rem_q;
        ec_d    = ec_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        od_d    = od_q;
        oid_d   = oid_q;
        ov_d    = 1'b0;
        last_d  = 1'b0;
        done_d  = 1'b0;
        to_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = READ;
                    id_d    = win;
                    rem_d   = bus.req_len[int'(win)*LEN_W +: LEN_W];
                    ec_d    = '0;
                    gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
                    busy_d  = 1'b1;
                    rr_d    = ID_W'((int'(win) + 1) % NUM_REQ);
                end
            end
            READ: begin
                if (rem_q == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (rinc) begin
                    ov_d  = 1'b1;
                    od_d  = bus.rdata;
                    oid_d = id_q;
                    rem_d = rem_q - 1'b1;
                    ec_d  = '0;
                    if (rem_q == LEN_W'(1)) begin
                        last_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                    end
                end else if (ec_q == EC_W'(MAX_EMPTY_RETRY - 1)) begin
                    to_d    = 1'b1;
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    ec_d = ec_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            rem_q   <= '0;
            ec_q    <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            oid_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            rem_q   <= rem_d;
            ec_q    <= ec_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            oid_q   <= oid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            to_q    <= to_d;
        end
    end

    assign bus.rinc      = rinc;
    assign bus.gnt       = gnt_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = ov_q;
    assign bus.out_data  = od_q;
    assign bus.out_id    = oid_q;
    assign bus.out_last  = last_q;
    assign bus.done      = done_q;
    assign bus.timeout   = to_q;
endmodule
